// File: rtl/wb_stage.sv
// Write-back stage: turns accepted results into one or two register-file
// write cycles and counts committed writes.
module wb_stage #(
  parameter int             D          = 16,
  parameter int             R          = 4,
  parameter int             F          = 4,
  parameter int             C          = 16,
  parameter logic [F-1:0]   PAIR_FUNCT = 4'hF,
  parameter logic [F-1:0]   NOWB_FUNCT = 4'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [F-1:0] funct4_i,
  input  logic [R-1:0] rd_i,
  input  logic [D-1:0] res_lo_i,
  input  logic [D-1:0] res_hi_i,
  output logic         we3,
  output logic [R-1:0] wa3,
  output logic [D-1:0] wd3,
  output logic [C-1:0] wb_count_o
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t       state_reg, state_next;
  logic [F-1:0] funct_reg;
  logic [R-1:0] rd_reg;
  logic [D-1:0] hi_reg;
  logic         pair_q;
  logic         accept;
  logic         load_lo;
  logic         load_hi;

  // The low word goes straight into wd3 at accept, so only the high word
  // needs holding for the second half of a pair.
  assign pair_q  = (funct_reg == PAIR_FUNCT);
  assign ready_o = !(state_reg == LO && pair_q);
  assign accept  = valid_i && ready_o;
  assign we3     = (state_reg == LO) || (state_reg == HI);

  always_comb begin
    state_next = IDLE;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    if (state_reg == LO && pair_q) begin
      state_next = HI;
      load_hi    = 1'b1;
    end else if (accept && funct4_i != NOWB_FUNCT) begin
      state_next = LO;
      load_lo    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      funct_reg  <= '0;
      rd_reg     <= '0;
      hi_reg     <= '0;
      wa3        <= '0;
      wd3        <= '0;
      wb_count_o <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        funct_reg <= funct4_i;
        rd_reg    <= rd_i;
        hi_reg    <= res_hi_i;
      end
      // Second pair address wraps within the register file.
      if (load_lo) begin
        wa3 <= rd_i;
        wd3 <= res_lo_i;
      end else if (load_hi) begin
        wa3 <= rd_reg + R'(1);
        wd3 <= hi_reg;
      end
      if (we3) begin
        wb_count_o <= wb_count_o + C'(1);
      end
    end
  end

endmodule
